// File: rtl/alu_result_monitor_if.sv
// Sample, counter and mismatch-log signals of the ALU result monitor.
// master = sample source / log reader side; slave = monitor side.
interface alu_result_monitor_if;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inc;
    logic [2:0]  opc;
    logic [15:0] w;
    logic        zer;
    logic        neg;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        log_rd;
    logic        log_empty;
    logic [2:0]  log_opc;
    logic [15:0] log_got;
    logic [15:0] log_exp;
    logic        log_ovf;

    modport master (
        output smp_valid, inA, inB, inc, opc, w, zer, neg, log_rd,
        input  smp_ready, pass_cnt, fail_cnt, log_empty, log_opc, log_got, log_exp, log_ovf
    );

    modport slave (
        input  smp_valid, inA, inB, inc, opc, w, zer, neg, log_rd,
        output smp_ready, pass_cnt, fail_cnt, log_empty, log_opc, log_got, log_exp, log_ovf
    );
endinterface

// File: rtl/alu_result_monitor.sv
// Checks ALU samples against a reference result; counters update 2 cycles after accept, ready only in IDLE
// (3-cycle cadence, 4 on mismatch). Mismatches go to an FWFT log; ALU_MON_FLAG_CHECK_EN also compares zer/neg.
module alu_result_monitor #(
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_monitor_if.slave  mon
);
    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, CALC, CMP, LOG} state_t;

    typedef struct packed {
        logic [2:0]  opc;
        logic [15:0] got;
        logic [15:0] exp;
    } log_ent_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, w_q, w_d, exp_q, exp_d;
    logic        inc_q, inc_d;
    logic [2:0]  opc_q, opc_d;
`ifdef ALU_MON_FLAG_CHECK_EN
    logic        zer_q, zer_d, neg_q, neg_d;
`endif
    logic [15:0] pass_q, pass_d, fail_q, fail_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    log_ent_t    hold_q, hold_d;
    log_ent_t    mem_q [LOG_DEPTH];

    logic [15:0] exp_calc;
    logic        mismatch;
    logic        push, pop, push_ok, fifo_full;
    log_ent_t    head, push_ent;

    always_comb begin
        case (opc_q)
            3'b000:  exp_calc = a_q + b_q + {15'd0, inc_q};
            3'b001:  exp_calc = a_q - b_q - {15'd0, inc_q};
            3'b010:  exp_calc = a_q & b_q;
            3'b011:  exp_calc = a_q | b_q;
            3'b100:  exp_calc = a_q ^ b_q;
            3'b101:  exp_calc = ~a_q;
            3'b110:  exp_calc = {a_q[14:0], inc_q};
            default: exp_calc = {inc_q, a_q[15:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        inc_d   = inc_q;
        opc_d   = opc_q;
        w_d     = w_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
`ifdef ALU_MON_FLAG_CHECK_EN
        zer_d    = zer_q;
        neg_d    = neg_q;
        mismatch = (w_q != exp_q) || (zer_q != (exp_q == 16'h0000)) || (neg_q != exp_q[15]);
`else
        mismatch = (w_q != exp_q);
`endif
        case (state_q)
            IDLE: begin
                if (mon.smp_valid) begin
                    state_d = CALC;
                    a_d     = mon.inA;
                    b_d     = mon.inB;
                    inc_d   = mon.inc;
                    opc_d   = mon.opc;
                    w_d     = mon.w;
`ifdef ALU_MON_FLAG_CHECK_EN
                    zer_d   = mon.zer;
                    neg_d   = mon.neg;
`endif
                end
            end
            CALC: begin
                exp_d   = exp_calc;
                state_d = CMP;
            end
            CMP: begin
                if (mismatch) begin
                    state_d = LOG;
                    if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
                end else begin
                    state_d = IDLE;
                    if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                end
            end
            LOG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A pop frees the slot before the push is judged, so full+pop+push never drops.
    always_comb begin
        push      = (state_q == LOG);
        pop       = mon.log_rd && (cnt_q != '0);
        fifo_full = (cnt_q == CW'(LOG_DEPTH));
        push_ok   = push && (!fifo_full || pop);
        push_ent  = '{opc: opc_q, got: w_q, exp: exp_q};
        head      = mem_q[rd_ptr_q];
        wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d     = cnt_q + CW'(push_ok) - CW'(pop);
        ovf_d     = ovf_q | (push && !push_ok);
        hold_d    = (cnt_q != '0) ? head : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            inc_q    <= 1'b0;
            opc_q    <= '0;
            w_q      <= '0;
            exp_q    <= '0;
`ifdef ALU_MON_FLAG_CHECK_EN
            zer_q    <= 1'b0;
            neg_q    <= 1'b0;
`endif
            pass_q   <= '0;
            fail_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            inc_q    <= inc_d;
            opc_q    <= opc_d;
            w_q      <= w_d;
            exp_q    <= exp_d;
`ifdef ALU_MON_FLAG_CHECK_EN
            zer_q    <= zer_d;
            neg_q    <= neg_d;
`endif
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_ent;
    end

    assign mon.smp_ready = (state_q == IDLE);
    assign mon.pass_cnt  = pass_q;
    assign mon.fail_cnt  = fail_q;
    assign mon.log_empty = (cnt_q == '0);
    assign mon.log_ovf   = ovf_q;
    assign {mon.log_opc, mon.log_got, mon.log_exp} = (cnt_q != '0) ? head : hold_q;
endmodule

// File: doc/alu_result_monitor.md
ALU_RESULT_MONITOR -- requirements
Module: alu_result_monitor

Interface
REQ-001 Parameter: LOG_DEPTH, default 4, number of entries in the mismatch log FIFO (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 smp_valid  input  1  sample offered.
REQ-005 smp_ready  output  1  monitor accepts a sample this cycle.
REQ-006 inA, inB  input  16 each  ALU operands, as driven to the ALU.
REQ-007 inc  input  1  ALU carry/shift-in bit.
REQ-008 opc  input  3  ALU opcode.
REQ-009 w  input  16  ALU result under check.
REQ-010 zer, neg  input  1 each  ALU flags under check.
REQ-011 pass_cnt, fail_cnt  output  16 each  checked-sample counters.
REQ-012 log_rd  input  1  pop one mismatch log entry.
REQ-013 log_empty  output  1  mismatch log holds no entries.
REQ-014 log_opc  output  3, log_got  output  16, log_exp  output  16  head entry of the mismatch log.
REQ-015 log_ovf  output  1  sticky: a mismatch was dropped because the log was full.

Function
REQ-016 Handshake: a sample transfers on a rising edge with smp_valid=1 and smp_ready=1; all sample inputs are captured into internal registers on that edge only.
REQ-017 FSM states: IDLE, CALC, CMP, LOG. smp_ready=1 only in IDLE.
REQ-018 IDLE -> CALC on transfer; CALC -> CMP unconditionally; CMP -> LOG on mismatch, else IDLE; LOG -> IDLE unconditionally.
REQ-019 CALC computes expected result E (16-bit, carries/borrows beyond bit 15 discarded): 000 A+B+inc; 001 A-B-inc; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 {A[14:0],inc}; 111 {inc,A[15:1]}.
REQ-020 Expected flags: zer_e = (E==16'h0000); neg_e = E[15].
REQ-021 CMP: mismatch when captured w != E (plus flag comparison per REQ-031); pass_cnt increments on match, fail_cnt increments on mismatch, both updated in the CMP cycle.
REQ-022 Counters saturate at 16'hFFFF; no wrap.
REQ-023 LOG: pushes {opc, captured w, E} into the FIFO if not full; if full, entry is dropped and log_ovf set to 1.
REQ-024 Sample-to-counter latency: 2 cycles after transfer edge; back-to-back throughput: one sample per 3 cycles (match) or 4 cycles (mismatch).
REQ-025 Log FIFO: first-word-fall-through; log_opc/log_got/log_exp show head entry, undefined-but-stable (hold last) when empty.
REQ-026 log_rd while log_empty=1 is ignored; log_rd in the same cycle as a push on a full FIFO pops first, then the push succeeds, log_ovf unchanged.
REQ-027 log_rd and push in the same cycle on a non-full, non-empty FIFO: occupancy unchanged, both take effect.
REQ-028 smp_valid asserted outside IDLE has no effect; inputs may change freely then.

Reset
REQ-029 rst_n low forces, immediately and independent of clk: state IDLE, smp_ready=1, pass_cnt=0, fail_cnt=0, log_empty=1, log_ovf=0, FIFO pointers 0, log data outputs 0.
REQ-030 Reset asserted mid-check (CALC/CMP/LOG) abandons the sample; no counter update or log push for it after release.

Configuration
REQ-031 Macro ALU_MON_FLAG_CHECK_EN: defined -> mismatch also when zer != zer_e or neg != neg_e, log_got bit fields unchanged; undefined -> zer and neg inputs ignored, only w compared.

Verification
REQ-032 opc=000, inA=16'h7FFF, inB=16'h0001, inc=0, w=16'h8000, neg=1, zer=0 -> pass_cnt=1 two cycles after transfer, log_empty stays 1.
REQ-033 opc=001, inA=16'h0005, inB=16'h0005, inc=0, w=16'h0001 -> fail_cnt=1, log entry {3'b001, 16'h0001, 16'h0000}, log_empty=0.
REQ-034 With ALU_MON_FLAG_CHECK_EN: opc=010, inA=16'h00F0, inB=16'h000F, w=16'h0000, zer=0 -> fail_cnt=1; without macro, same stimulus -> pass_cnt=1.
REQ-035 Five consecutive mismatches with log_rd=0, LOG_DEPTH=4 -> four entries retained in order, log_ovf=1, fail_cnt=5.
REQ-036 Assert rst_n=0 during CMP of a mismatching sample -> all outputs at reset values immediately, fail_cnt remains 0 after release.
REQ-037 Hold smp_valid=1 with 8 matching samples (opc 000..111) -> smp_ready pulses once per 3 cycles, pass_cnt=8, no sample lost or duplicated.
